// File: rtl/tdc_pkg.sv
//------------------------------------------------------------------------------
// tdc_pkg : shared constants and state type for the TDC measurement sequencer
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tdc_pkg;

    localparam int CTR_NUM = 8;
    localparam int FRAC_W  = 7;
    localparam int FINE_W  = FRAC_W + $clog2(CTR_NUM);
    localparam int SYNC_W  = CTR_NUM * FRAC_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAP_START = 3'd1,
        ST_RUN       = 3'd2,
        ST_CAP_STOP  = 3'd3,
        ST_OUT       = 3'd4
    } tdc_state_t;

endpackage

`default_nettype wire

// File: rtl/frac_sum.sv
//------------------------------------------------------------------------------
// frac_sum : combinational sum of the fractional counter lanes of one snapshot
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frac_sum
    import tdc_pkg::*;
(
    input  logic [SYNC_W-1:0] sync_data_i,
    output logic [FINE_W-1:0] sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < CTR_NUM; i++) begin
            sum_o = sum_o + FINE_W'(sync_data_i[FRAC_W*i +: FRAC_W]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdc_meas_ctrl.sv
//------------------------------------------------------------------------------
// tdc_meas_ctrl : start/stop measurement sequencer producing coarse + fine records
// Optional watchdog enabled by macro TDC_TIMEOUT_EN.  Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int COARSE_W = 24
`ifdef TDC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int FINE_WAIT   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                sync_valid_i,
    input  logic [SYNC_W-1:0]   sync_data_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [COARSE_W-1:0] res_coarse_o,
    output logic [FINE_W-1:0]   res_fine_start_o,
    output logic [FINE_W-1:0]   res_fine_stop_o,
    output logic                res_timeout_o,
    output logic                busy_o,
    output logic [7:0]          overrun_cnt_o
);

    tdc_state_t          state_q, state_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [COARSE_W-1:0] res_coarse_q, res_coarse_d;
    logic [FINE_W-1:0]   fine_start_q, fine_start_d;
    logic [FINE_W-1:0]   fine_stop_q, fine_stop_d;
    logic                stop_pend_q, stop_pend_d;
    logic [7:0]          overrun_q, overrun_d;
    logic [FINE_W-1:0]   w_lane_sum;
    logic                w_count_en;

`ifdef TDC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(FINE_WAIT + 1);
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    frac_sum u_frac_sum (
        .sync_data_i (sync_data_i),
        .sum_o       (w_lane_sum)
    );

    // Coarse freezes once stop has been seen while still waiting for the start snapshot.
    assign w_count_en = (state_q == ST_RUN) || ((state_q == ST_CAP_START) && !stop_pend_q);

    always_comb begin
        state_d      = state_q;
        coarse_d     = coarse_q;
        res_coarse_d = res_coarse_q;
        fine_start_d = fine_start_q;
        fine_stop_d  = fine_stop_q;
        stop_pend_d  = stop_pend_q;
        overrun_d    = overrun_q;
`ifdef TDC_TIMEOUT_EN
        timeout_d    = timeout_q;
        wait_d       = wait_q;
`endif

        if (w_count_en && (coarse_q != '1)) begin
            coarse_d = coarse_q + COARSE_W'(1);
        end

        if (start_i && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_CAP_START;
                    coarse_d    = '0;
                    stop_pend_d = 1'b0;
`ifdef TDC_TIMEOUT_EN
                    timeout_d   = 1'b0;
                    wait_d      = '0;
`endif
                end
            end
            ST_CAP_START: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (sync_valid_i) begin
                    fine_start_d = w_lane_sum;
                    state_d      = (stop_pend_q || stop_i) ? ST_CAP_STOP : ST_RUN;
`ifdef TDC_TIMEOUT_EN
                    wait_d       = '0;
                end else if (wait_q == WAIT_W'(FINE_WAIT - 1)) begin
                    state_d      = ST_OUT;
                    timeout_d    = 1'b1;
                    fine_start_d = '0;
                    fine_stop_d  = '0;
                end else begin
                    wait_d       = wait_q + WAIT_W'(1);
`endif
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_CAP_STOP;
`ifdef TDC_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            ST_CAP_STOP: begin
                if (sync_valid_i) begin
                    fine_stop_d = w_lane_sum;
                    state_d     = ST_OUT;
`ifdef TDC_TIMEOUT_EN
                end else if (wait_q == WAIT_W'(FINE_WAIT - 1)) begin
                    state_d     = ST_OUT;
                    timeout_d   = 1'b1;
                    fine_stop_d = '0;
                end else begin
                    wait_d      = wait_q + WAIT_W'(1);
`endif
                end
            end
            ST_OUT: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef TDC_TIMEOUT_EN
        // Coarse watchdog overrides whatever the capture states decided this cycle.
        if (w_count_en && (coarse_q != '1) &&
            ((32'(coarse_q) + 32'd1) == 32'(TIMEOUT_CYC))) begin
            state_d     = ST_OUT;
            timeout_d   = 1'b1;
            fine_stop_d = '0;
            if ((state_q == ST_CAP_START) && !sync_valid_i) begin
                fine_start_d = '0;
            end
        end
`endif

        if ((state_d == ST_OUT) && (state_q != ST_OUT)) begin
            res_coarse_d = coarse_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            coarse_q     <= '0;
            res_coarse_q <= '0;
            fine_start_q <= '0;
            fine_stop_q  <= '0;
            stop_pend_q  <= 1'b0;
            overrun_q    <= '0;
`ifdef TDC_TIMEOUT_EN
            timeout_q    <= 1'b0;
            wait_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            coarse_q     <= coarse_d;
            res_coarse_q <= res_coarse_d;
            fine_start_q <= fine_start_d;
            fine_stop_q  <= fine_stop_d;
            stop_pend_q  <= stop_pend_d;
            overrun_q    <= overrun_d;
`ifdef TDC_TIMEOUT_EN
            timeout_q    <= timeout_d;
            wait_q       <= wait_d;
`endif
        end
    end

    assign res_valid_o      = (state_q == ST_OUT);
    assign busy_o           = (state_q != ST_IDLE);
    assign res_coarse_o     = res_coarse_q;
    assign res_fine_start_o = fine_start_q;
    assign res_fine_stop_o  = fine_stop_q;
    assign overrun_cnt_o    = overrun_q;
`ifdef TDC_TIMEOUT_EN
    assign res_timeout_o    = timeout_q;
`else
    assign res_timeout_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdc_meas_ctrl.sv
//------------------------------------------------------------------------------
// tb_tdc_meas_ctrl : randomized self-checking bench for tdc_meas_ctrl
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdc_meas_ctrl;
    import tdc_pkg::*;

    localparam int CW         = 24;
    localparam int CW4        = 4;
    localparam int TB_TIMEOUT = 100;
    localparam int SLEN       = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, stop, sv_in, ready;
    logic [SYNC_W-1:0] sd;

    logic              valid, tout, busy;
    logic [CW-1:0]     coarse;
    logic [FINE_W-1:0] fstart, fstop;
    logic [7:0]        ovr;

    logic              valid4, tout4, busy4;
    logic [CW4-1:0]    coarse4;
    logic [FINE_W-1:0] fstart4, fstop4;
    logic [7:0]        ovr4;

    tdc_meas_ctrl #(
        .COARSE_W(CW)
`ifdef TDC_TIMEOUT_EN
        , .TIMEOUT_CYC(TB_TIMEOUT)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .sync_valid_i(sv_in), .sync_data_i(sd), .res_valid_o(valid),
        .res_ready_i(ready), .res_coarse_o(coarse), .res_fine_start_o(fstart),
        .res_fine_stop_o(fstop), .res_timeout_o(tout), .busy_o(busy),
        .overrun_cnt_o(ovr)
    );

    tdc_meas_ctrl #(
        .COARSE_W(CW4)
`ifdef TDC_TIMEOUT_EN
        , .TIMEOUT_CYC(TB_TIMEOUT)
`endif
    ) dut4 (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .sync_valid_i(sv_in), .sync_data_i(sd), .res_valid_o(valid4),
        .res_ready_i(ready), .res_coarse_o(coarse4), .res_fine_start_o(fstart4),
        .res_fine_stop_o(fstop4), .res_timeout_o(tout4), .busy_o(busy4),
        .overrun_cnt_o(ovr4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_ovr  = 0;

    // Event schedule of one measurement, indexed by cycle from the idle point.
    bit                s_sv [SLEN];
    bit                s_st [SLEN];
    bit                s_sp [SLEN];
    logic [SYNC_W-1:0] s_ln [SLEN];
    int                s0, sp, hold;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lane_sum(input logic [SYNC_W-1:0] d);
        int s = 0;
        for (int i = 0; i < CTR_NUM; i++) s += int'(d[FRAC_W*i +: FRAC_W]);
        return s;
    endfunction

    function automatic logic [SYNC_W-1:0] rand_lanes();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[SYNC_W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; sv_in = 1'b0; ready = 1'b0; sd = '0;
    endtask

    task automatic clear_sched();
        for (int t = 0; t < SLEN; t++) begin
            s_sv[t] = 1'b0; s_st[t] = 1'b0; s_sp[t] = 1'b0; s_ln[t] = '0;
        end
    endtask

    task automatic gen_random();
        clear_sched();
        s0   = 2 + $urandom_range(0, 3);
        sp   = s0 + 1 + $urandom_range(0, 40);
        hold = $urandom_range(0, 12);
        for (int t = 0; t < SLEN; t++) begin
            s_ln[t] = rand_lanes();
            s_sv[t] = (t % 8 == 0) || ($urandom_range(0, 3) == 0);
            s_sp[t] = ((t <= s0) || (t > sp)) && ($urandom_range(0, 9) == 0);
        end
    endtask

    // Expected record comes from the schedule: coarse = stop - start, fine values from
    // the first snapshot after start and the first unused snapshot after stop.
    task automatic run_txn(input bit rand_extra, input string name);
        int tfs, tfss, vt, a, n_ovr, exp_c, exp_c4, fs, fst;
        logic [63:0] exp_rec;
        bit ok;
        tfs = -1; tfss = -1; n_ovr = 0;
        s_st[s0] = 1'b1;
        s_sp[sp] = 1'b1;
        for (int t = s0 + 1; t < SLEN && tfs < 0; t++) if (s_sv[t]) tfs = t;
        if (tfs >= 0) begin
            for (int t = ((sp > tfs) ? sp : tfs) + 1; t < SLEN && tfss < 0; t++)
                if (s_sv[t]) tfss = t;
        end
        ok = (tfs >= 0) && (tfss >= 0) && (tfss + hold + 3 < SLEN);
        check_eq({name, "_sched"}, 64'(ok), 64'd1);
        if (!ok) return;
        vt = tfss + 1;
        a  = vt + hold;
        if (rand_extra) begin
            for (int t = s0 + 1; t <= a; t++) s_st[t] = ($urandom_range(0, 7) == 0);
        end
        for (int t = s0 + 1; t <= a; t++) if (s_st[t]) n_ovr++;
        exp_ovr = (exp_ovr + n_ovr > 255) ? 255 : exp_ovr + n_ovr;
        exp_c   = sp - s0;
        exp_c4  = (exp_c > 15) ? 15 : exp_c;
        fs      = lane_sum(s_ln[tfs]);
        fst     = lane_sum(s_ln[tfss]);
        exp_rec = 64'({1'b1, CW'(exp_c), FINE_W'(fs), FINE_W'(fst), 1'b0});
        for (int t = 0; t <= a + 1; t++) begin
            start = (t <= a) ? s_st[t] : 1'b0;
            stop  = s_sp[t];
            sv_in = s_sv[t];
            sd    = s_ln[t];
            ready = (t == a);
            if (t == s0)     check_eq({name, "_busy_idle"}, 64'(busy), 64'd0);
            if (t == s0 + 1) check_eq({name, "_busy_run"}, 64'(busy), 64'd1);
            if (t == vt - 1) check_eq({name, "_valid_early"}, 64'(valid), 64'd0);
            if (t >= vt && t <= a)
                check_eq({name, "_rec"}, 64'({valid, coarse, fstart, fstop, tout}), exp_rec);
`ifndef TDC_TIMEOUT_EN
            if (t == vt) check_eq({name, "_coarse4"}, 64'(coarse4), 64'(exp_c4));
`endif
            if (t == a + 1) begin
                check_eq({name, "_busy_done"}, 64'({busy, valid}), 64'd0);
                check_eq({name, "_overrun"}, 64'(ovr), 64'(exp_ovr));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic basic_test();
        clear_sched();
        s0 = 10; sp = 50; hold = 20;
        s_sv[12] = 1'b1;
        s_sv[53] = 1'b1;
        for (int i = 0; i < CTR_NUM; i++) begin
            s_ln[12][FRAC_W*i +: FRAC_W] = FRAC_W'(5);
            s_ln[53][FRAC_W*i +: FRAC_W] = FRAC_W'(i + 1);
        end
        s_st[60] = 1'b1; s_st[65] = 1'b1; s_st[70] = 1'b1;
        run_txn(1'b0, "basic");
    endtask

    task automatic early_stop_test();
        clear_sched();
        s0 = 10; sp = 11; hold = 3;
        s_sv[14] = 1'b1; s_ln[14] = rand_lanes();
        s_sv[18] = 1'b1; s_ln[18] = rand_lanes();
        run_txn(1'b0, "early");
    endtask

    task automatic reset_test();
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            sv_in = (k % 4 == 1);
            sd    = rand_lanes();
            start = (k == 6);
            step();
        end
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        exp_ovr = 0;
        check_eq("rst_valid_busy", 64'({valid, busy}), 64'd0);
        check_eq("rst_overrun", 64'(ovr), 64'(exp_ovr));
        check_eq("rst_rec", 64'({coarse, fstart, fstop, tout}), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic overrun_sat_test();
        int k;
        idle_inputs();
        start = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            start = 1'b1;
            sv_in = (i % 4 == 0);
            sd    = rand_lanes();
            step();
        end
        idle_inputs();
        exp_ovr = (exp_ovr + 300 > 255) ? 255 : exp_ovr + 300;
        stop = 1'b1;
        step();
        stop = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            sv_in = (k % 3 == 0);
            ready = 1'b1;
            step();
            k++;
        end
        idle_inputs();
        check_eq("sat_drain_busy", 64'(busy), 64'd0);
        check_eq("sat_overrun", 64'(ovr), 64'(exp_ovr));
        step();
    endtask

    task automatic timeout_test();
`ifdef TDC_TIMEOUT_EN
        int k, fs;
        logic [SYNC_W-1:0] d;
        fs = -1;
        k  = 0;
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        while (!valid && k < 300) begin
            k++;
            d     = rand_lanes();
            sv_in = (k % 8 == 0);
            sd    = d;
            if (sv_in && fs < 0) fs = lane_sum(d);
            step();
        end
        idle_inputs();
        check_eq("to_valid", 64'(valid), 64'd1);
        check_eq("to_rec", 64'({coarse, fstart, fstop, tout}),
                 64'({CW'(TB_TIMEOUT), FINE_W'(fs), FINE_W'(0), 1'b1}));
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_eq("to_busy_done", 64'(busy), 64'd0);
        // dut4 cannot reach the watchdog count, so bring it back to idle as well.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ovr = 0;
        step();
`else
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            sv_in = (i % 5 == 0);
            sd    = rand_lanes();
            step();
        end
        idle_inputs();
        check_eq("no_to_busy", 64'({busy, valid}), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ovr = 0;
        step();
`endif
    endtask

    task automatic random_block(input int n);
        for (int i = 0; i < n; i++) begin
            gen_random();
            run_txn(1'b1, "rand");
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        check_eq("reset_out", 64'({valid, busy, tout, ovr}), 64'd0);
        check_eq("reset_rec", 64'({coarse, fstart, fstop}), 64'd0);
        rst = 1'b0;
        step();
        basic_test();
        early_stop_test();
        random_block(10);
        reset_test();
        random_block(10);
        overrun_sat_test();
        timeout_test();
        random_block(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
